// File: rtl/apb_req_arbiter_if.sv
// Bundle between two requesters, the request arbiter and the APB master it feeds.
// The master modport is the arbiter's side; the slave modport is the surrounding logic.
interface apb_req_arbiter_if;
    logic       req_a;
    logic       req_b;
    logic       rw_a;
    logic       rw_b;
    logic [8:0] addr_a;
    logic [8:0] addr_b;
    logic [7:0] wdata_a;
    logic [7:0] wdata_b;
    logic       gnt_a;
    logic       gnt_b;
    logic       done_a;
    logic       done_b;
    logic [7:0] rdata;
    logic       err;
    logic       m_transfer;
    logic       m_read_write;
    logic [8:0] m_write_paddr;
    logic [8:0] m_read_paddr;
    logic [7:0] m_write_data;
    logic       m_penable;
    logic       m_pready;
    logic       m_pslverr;
    logic [7:0] m_read_data;

    modport master (
        input  req_a, req_b, rw_a, rw_b, addr_a, addr_b, wdata_a, wdata_b,
               m_penable, m_pready, m_pslverr, m_read_data,
        output gnt_a, gnt_b, done_a, done_b, rdata, err,
               m_transfer, m_read_write, m_write_paddr, m_read_paddr, m_write_data
    );

    modport slave (
        output req_a, req_b, rw_a, rw_b, addr_a, addr_b, wdata_a, wdata_b,
               m_penable, m_pready, m_pslverr, m_read_data,
        input  gnt_a, gnt_b, done_a, done_b, rdata, err,
               m_transfer, m_read_write, m_write_paddr, m_read_paddr, m_write_data
    );
endinterface

// File: rtl/apb_req_arbiter.sv
// Round-robin arbiter for two requesters that runs exactly one APB transfer per
// grant through the APB master, with a PREADY timeout so a stalled slave cannot hang it.
module apb_req_arbiter #(
    parameter int TIMEOUT = 16
) (
    input  logic              PCLK,
    input  logic              PRESET,
    apb_req_arbiter_if.master bus
);

    typedef enum logic [3:0] {
        IDLE = 4'b0001,
        LOAD = 4'b0010,
        XFER = 4'b0100,
        RESP = 4'b1000
    } state_t;

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_t     state, state_nxt;

    logic       ptr_b, ptr_b_d;
    logic       owner_b, owner_b_d;
    logic       cmd_rw, cmd_rw_d;
    logic [8:0] cmd_addr, cmd_addr_d;
    logic [7:0] cmd_wdata, cmd_wdata_d;
    logic [7:0] tmo_cnt, tmo_cnt_d;
    logic       err_pend, err_pend_d;

    logic       gnt_a_d, gnt_b_d, done_a_d, done_b_d, err_d;
    logic       transfer_d, read_write_d;
    logic [8:0] paddr_d;
    logic [7:0] write_data_d, rdata_d;

    logic       any_req, win_b;
    logic       xfer_err, xfer_ok, xfer_tmo;

    // With both requesting, the side the pointer names wins.
    assign any_req  = bus.req_a | bus.req_b;
    assign win_b    = bus.req_b & (~bus.req_a | ptr_b);
    assign xfer_err = bus.m_pslverr;
    assign xfer_ok  = bus.m_penable & bus.m_pready;
    assign xfer_tmo = (tmo_cnt == TMO_LAST);

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req) state_nxt = LOAD;
            LOAD:    state_nxt = XFER;
            XFER:    if (xfer_err || xfer_ok || xfer_tmo) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Next values of every registered output and of the command/priority state.
    always_comb begin
        gnt_a_d      = bus.gnt_a;
        gnt_b_d      = bus.gnt_b;
        done_a_d     = 1'b0;
        done_b_d     = 1'b0;
        err_d        = 1'b0;
        transfer_d   = bus.m_transfer;
        read_write_d = bus.m_read_write;
        paddr_d      = bus.m_write_paddr;
        write_data_d = bus.m_write_data;
        rdata_d      = bus.rdata;
        ptr_b_d      = ptr_b;
        owner_b_d    = owner_b;
        cmd_rw_d     = cmd_rw;
        cmd_addr_d   = cmd_addr;
        cmd_wdata_d  = cmd_wdata;
        tmo_cnt_d    = tmo_cnt;
        err_pend_d   = err_pend;
        case (state)
            IDLE: begin
                if (any_req) begin
                    owner_b_d   = win_b;
                    gnt_a_d     = ~win_b;
                    gnt_b_d     = win_b;
                    cmd_rw_d    = win_b ? bus.rw_b    : bus.rw_a;
                    cmd_addr_d  = win_b ? bus.addr_b  : bus.addr_a;
                    cmd_wdata_d = win_b ? bus.wdata_b : bus.wdata_a;
                end
            end
            LOAD: begin
                transfer_d   = 1'b1;
                read_write_d = cmd_rw;
                paddr_d      = cmd_addr;
                write_data_d = cmd_wdata;
                tmo_cnt_d    = 8'd0;
            end
            XFER: begin
                tmo_cnt_d = tmo_cnt + 8'd1;
                if (xfer_err) begin
                    transfer_d = 1'b0;
                    err_pend_d = 1'b1;
                end else if (xfer_ok) begin
                    transfer_d = 1'b0;
                    err_pend_d = 1'b0;
                    if (cmd_rw) rdata_d = bus.m_read_data;
                end else if (xfer_tmo) begin
                    transfer_d = 1'b0;
                    err_pend_d = 1'b1;
                end
            end
            RESP: begin
                done_a_d = ~owner_b;
                done_b_d = owner_b;
                err_d    = err_pend;
                gnt_a_d  = 1'b0;
                gnt_b_d  = 1'b0;
                ptr_b_d  = ~owner_b;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            bus.gnt_a         <= 1'b0;
            bus.gnt_b         <= 1'b0;
            bus.done_a        <= 1'b0;
            bus.done_b        <= 1'b0;
            bus.err           <= 1'b0;
            bus.rdata         <= 8'd0;
            bus.m_transfer    <= 1'b0;
            bus.m_read_write  <= 1'b0;
            bus.m_write_paddr <= 9'd0;
            bus.m_read_paddr  <= 9'd0;
            bus.m_write_data  <= 8'd0;
            ptr_b             <= 1'b0;
            owner_b           <= 1'b0;
            cmd_rw            <= 1'b0;
            cmd_addr          <= 9'd0;
            cmd_wdata         <= 8'd0;
            tmo_cnt           <= 8'd0;
            err_pend          <= 1'b0;
        end else begin
            bus.gnt_a         <= gnt_a_d;
            bus.gnt_b         <= gnt_b_d;
            bus.done_a        <= done_a_d;
            bus.done_b        <= done_b_d;
            bus.err           <= err_d;
            bus.rdata         <= rdata_d;
            bus.m_transfer    <= transfer_d;
            bus.m_read_write  <= read_write_d;
            bus.m_write_paddr <= paddr_d;
            bus.m_read_paddr  <= paddr_d;
            bus.m_write_data  <= write_data_d;
            ptr_b             <= ptr_b_d;
            owner_b           <= owner_b_d;
            cmd_rw            <= cmd_rw_d;
            cmd_addr          <= cmd_addr_d;
            cmd_wdata         <= cmd_wdata_d;
            tmo_cnt           <= tmo_cnt_d;
            err_pend          <= err_pend_d;
        end
    end

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Directed bench for apb_req_arbiter with a small APB master/slave model behind it.
// Each scenario task drives its own vectors and compares against hand-derived cycle tables.
module tb_apb_req_arbiter;

    logic PCLK;
    logic PRESET;

    apb_req_arbiter_if bus ();

    apb_req_arbiter #(.TIMEOUT(8)) dut (
        .PCLK   (PCLK),
        .PRESET (PRESET),
        .bus    (bus)
    );

    int checks = 0;
    int errors = 0;

    typedef enum logic [1:0] {M_IDLE, M_SETUP, M_ENABLE} mst_t;
    mst_t       mst;
    int         w_cnt;
    int         waits;
    logic       stuck;
    logic       err_en;
    logic [7:0] rd_val;
    logic [7:0] exp_rdata;

    logic [5:0]  hs;
    logic [40:0] all_outs;

    assign hs = {bus.gnt_a, bus.gnt_b, bus.done_a, bus.done_b, bus.m_transfer, bus.err};
    assign all_outs = {bus.gnt_a, bus.gnt_b, bus.done_a, bus.done_b, bus.err, bus.m_transfer,
                       bus.m_read_write, bus.m_write_paddr, bus.m_read_paddr,
                       bus.m_write_data, bus.rdata};

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    // APB master behaviour as seen from its transfer input, plus a slave with wait states.
    always @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            mst   <= M_IDLE;
            w_cnt <= 0;
        end else begin
            case (mst)
                M_IDLE:   if (bus.m_transfer) mst <= M_SETUP;
                M_SETUP:  mst <= bus.m_transfer ? M_ENABLE : M_IDLE;
                M_ENABLE: if (bus.m_pready) mst <= bus.m_transfer ? M_SETUP : M_IDLE;
                default:  mst <= M_IDLE;
            endcase
            w_cnt <= (bus.m_penable && !bus.m_pready) ? w_cnt + 1 : 0;
        end
    end

    assign bus.m_penable   = (mst == M_ENABLE);
    assign bus.m_pready    = bus.m_penable && !stuck && (w_cnt >= waits);
    assign bus.m_pslverr   = err_en && bus.m_penable;
    assign bus.m_read_data = rd_val;

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    task automatic test_reset();
        PRESET = 1'b1;
        tick();
        tick();
        checks++;
        if (all_outs !== 41'd0) begin
            errors++;
            $display("[TB] FAIL reset_values got=%h exp=%h", all_outs, 41'd0);
        end
        PRESET = 1'b0;
        tick();
        tick();
        tick();
        checks++;
        if (all_outs !== 41'd0) begin
            errors++;
            $display("[TB] FAIL idle_after_reset got=%h exp=%h", all_outs, 41'd0);
        end
    endtask

    task automatic test_single_write();
        logic [5:0] exp;
        tick();
        bus.req_a = 1'b1; bus.rw_a = 1'b0; bus.addr_a = 9'h012; bus.wdata_a = 8'hA5;
        waits = 0;
        for (int k = 1; k <= 7; k++) begin
            tick();
            exp = {k <= 5, 1'b0, k == 6, 1'b0, k >= 2 && k <= 4, 1'b0};
            checks++;
            if (hs !== exp) begin
                errors++;
                $display("[TB] FAIL write_handshake k=%0d got=%b exp=%b", k, hs, exp);
            end
            if (k == 1) begin
                bus.addr_a = 9'h0FF; bus.wdata_a = 8'hFF;
            end
            if (k == 2 || k == 4) begin
                checks++;
                if ({bus.m_read_write, bus.m_write_paddr, bus.m_read_paddr, bus.m_write_data}
                    !== {1'b0, 9'h012, 9'h012, 8'hA5}) begin
                    errors++;
                    $display("[TB] FAIL write_command k=%0d got=%b/%h/%h/%h exp=0/012/012/a5", k,
                             bus.m_read_write, bus.m_write_paddr, bus.m_read_paddr, bus.m_write_data);
                end
            end
            if (k == 6) bus.req_a = 1'b0;
        end
    endtask

    task automatic test_read_wait();
        logic [5:0] exp;
        tick();
        bus.req_b = 1'b1; bus.rw_b = 1'b1; bus.addr_b = 9'h105;
        waits = 2; rd_val = 8'h3C;
        for (int k = 1; k <= 9; k++) begin
            tick();
            exp = {1'b0, k <= 7, 1'b0, k == 8, k >= 2 && k <= 6, 1'b0};
            checks++;
            if (hs !== exp) begin
                errors++;
                $display("[TB] FAIL read_handshake k=%0d got=%b exp=%b", k, hs, exp);
            end
            if (k == 2) begin
                checks++;
                if ({bus.m_read_write, bus.m_write_paddr, bus.m_read_paddr} !== {1'b1, 9'h105, 9'h105}) begin
                    errors++;
                    $display("[TB] FAIL read_command got=%b/%h/%h exp=1/105/105",
                             bus.m_read_write, bus.m_write_paddr, bus.m_read_paddr);
                end
            end
            if (k == 3) bus.req_b = 1'b0;
            if (k == 8) begin
                checks++;
                if (bus.rdata !== 8'h3C) begin
                    errors++;
                    $display("[TB] FAIL read_data got=%h exp=3c", bus.rdata);
                end
            end
        end
        exp_rdata = 8'h3C;
        waits = 0;
    endtask

    task automatic test_contention();
        int dn;
        bit want_gnt;
        bit next_b;
        dn = 0; want_gnt = 1'b0; next_b = 1'b0;
        PRESET = 1'b1;
        bus.req_a = 1'b1; bus.rw_a = 1'b0; bus.addr_a = 9'h0AA; bus.wdata_a = 8'h11;
        bus.req_b = 1'b1; bus.rw_b = 1'b1; bus.addr_b = 9'h1BB;
        rd_val = 8'h5A; waits = 0;
        tick();
        PRESET = 1'b0;
        for (int k = 0; k < 60 && dn < 4; k++) begin
            tick();
            checks++;
            if (bus.gnt_a && bus.gnt_b) begin
                errors++;
                $display("[TB] FAIL contention_both_gnt k=%0d got=11 exp=not_both", k);
            end
            if (want_gnt) begin
                checks++;
                if ({bus.gnt_a, bus.gnt_b} !== {!next_b, next_b}) begin
                    errors++;
                    $display("[TB] FAIL contention_next_gnt k=%0d got=%b%b exp=%b%b",
                             k, bus.gnt_a, bus.gnt_b, !next_b, next_b);
                end
                want_gnt = 1'b0;
            end
            if (bus.done_a || bus.done_b) begin
                checks++;
                if ({bus.done_a, bus.done_b, bus.err} !== {dn % 2 == 0, dn % 2 == 1, 1'b0}) begin
                    errors++;
                    $display("[TB] FAIL contention_order n=%0d got=%b%b err=%b exp=%b%b err=0",
                             dn, bus.done_a, bus.done_b, bus.err, dn % 2 == 0, dn % 2 == 1);
                end
                if (dn % 2 == 1) begin
                    checks++;
                    if (bus.rdata !== 8'h5A) begin
                        errors++;
                        $display("[TB] FAIL contention_rdata n=%0d got=%h exp=5a", dn, bus.rdata);
                    end
                end
                dn++;
                if (dn < 4) begin
                    want_gnt = 1'b1;
                    next_b   = (dn % 2 == 1);
                end else begin
                    bus.req_a = 1'b0;
                    bus.req_b = 1'b0;
                end
            end
        end
        checks++;
        if (dn != 4) begin
            errors++;
            $display("[TB] FAIL contention_count got=%0d exp=4", dn);
        end
        bus.req_a = 1'b0;
        bus.req_b = 1'b0;
        exp_rdata = 8'h5A;
    endtask

    task automatic test_timeout();
        logic [5:0] exp;
        tick();
        stuck = 1'b1; waits = 0;
        bus.req_a = 1'b1; bus.rw_a = 1'b0; bus.addr_a = 9'h033; bus.wdata_a = 8'h44;
        bus.req_b = 1'b1; bus.rw_b = 1'b0; bus.addr_b = 9'h144; bus.wdata_b = 8'h55;
        for (int k = 1; k <= 18; k++) begin
            tick();
            exp = {k <= 10, k >= 12 && k <= 16, k == 11, k == 17,
                   (k >= 2 && k <= 9) || (k >= 13 && k <= 15), k == 11};
            checks++;
            if (hs !== exp) begin
                errors++;
                $display("[TB] FAIL timeout_handshake k=%0d got=%b exp=%b", k, hs, exp);
            end
            if (k == 11) begin
                bus.req_a = 1'b0;
                stuck = 1'b0;
            end
            if (k == 14) begin
                checks++;
                if ({bus.m_write_paddr, bus.m_write_data} !== {9'h144, 8'h55}) begin
                    errors++;
                    $display("[TB] FAIL timeout_b_command got=%h/%h exp=144/55",
                             bus.m_write_paddr, bus.m_write_data);
                end
            end
            if (k == 17) bus.req_b = 1'b0;
        end
    endtask

    task automatic test_slave_error();
        logic [5:0] exp;
        tick();
        bus.req_a = 1'b1; bus.rw_a = 1'b1; bus.addr_a = 9'h077;
        waits = 0; err_en = 1'b1; rd_val = 8'hEE;
        for (int k = 1; k <= 7; k++) begin
            tick();
            exp = {k <= 5, 1'b0, k == 6, 1'b0, k >= 2 && k <= 4, k == 6};
            checks++;
            if (hs !== exp) begin
                errors++;
                $display("[TB] FAIL slverr_handshake k=%0d got=%b exp=%b", k, hs, exp);
            end
            if (k == 6) begin
                checks++;
                if (bus.rdata !== exp_rdata) begin
                    errors++;
                    $display("[TB] FAIL slverr_rdata_held got=%h exp=%h", bus.rdata, exp_rdata);
                end
                bus.req_a = 1'b0;
            end
        end
        err_en = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [5:0] exp;
        tick();
        bus.req_a = 1'b1; bus.rw_a = 1'b0; bus.addr_a = 9'h0C3; bus.wdata_a = 8'h9E;
        waits = 0;
        tick();
        tick();
        tick();
        checks++;
        if (bus.m_transfer !== 1'b1) begin
            errors++;
            $display("[TB] FAIL midreset_in_xfer got=%b exp=1", bus.m_transfer);
        end
        PRESET = 1'b1;
        #1;
        checks++;
        if (all_outs !== 41'd0) begin
            errors++;
            $display("[TB] FAIL midreset_async_clear got=%h exp=%h", all_outs, 41'd0);
        end
        bus.req_a = 1'b0;
        bus.req_b = 1'b1; bus.rw_b = 1'b1; bus.addr_b = 9'h0F0;
        rd_val = 8'h77;
        tick();
        PRESET = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            tick();
            exp = {1'b0, k <= 5, 1'b0, k == 6, k >= 2 && k <= 4, 1'b0};
            checks++;
            if (hs !== exp) begin
                errors++;
                $display("[TB] FAIL midreset_regrant k=%0d got=%b exp=%b", k, hs, exp);
            end
            if (k == 6) begin
                checks++;
                if (bus.rdata !== 8'h77) begin
                    errors++;
                    $display("[TB] FAIL midreset_rdata got=%h exp=77", bus.rdata);
                end
                bus.req_b = 1'b0;
            end
        end
        exp_rdata = 8'h77;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired got=running exp=finished");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        PRESET      = 1'b1;
        bus.req_a   = 1'b0;
        bus.req_b   = 1'b0;
        bus.rw_a    = 1'b0;
        bus.rw_b    = 1'b0;
        bus.addr_a  = 9'd0;
        bus.addr_b  = 9'd0;
        bus.wdata_a = 8'd0;
        bus.wdata_b = 8'd0;
        waits       = 0;
        stuck       = 1'b0;
        err_en      = 1'b0;
        rd_val      = 8'd0;
        exp_rdata   = 8'd0;

        test_reset();
        test_single_write();
        test_read_wait();
        test_contention();
        test_timeout();
        test_slave_error();
        test_reset_mid();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/apb_req_arbiter.md
# apb_req_arbiter

Two-port request arbiter and sequencer in front of the APB master. It accepts single read/write commands from two independent requesters and grants the master to one at a time using round-robin priority. It drives the master's transfer/command inputs for exactly one APB transfer per grant and returns read data, completion and error status to the winning requester. It also enforces a PREADY timeout so a stalled slave cannot lock out the other requester.

## Interface
Parameters:
- TIMEOUT, 16: maximum PCLK cycles spent in XFER before the transfer is aborted with error; legal range 2..255.

Ports (reset is asynchronous, active-high):
- PCLK  input  1  clock, all logic on rising edge
- PRESET  input  1  asynchronous active-high reset
- req_a / req_b  input  1  requester command valid; held high until the matching done pulse
- rw_a / rw_b  input  1  1 = read, 0 = write (same encoding as the master's READ_WRITE)
- addr_a / addr_b  input  9  target address; bit 8 selects slave 2
- wdata_a / wdata_b  input  8  write data
- gnt_a / gnt_b  output  1  high from LOAD through RESP for the owning requester
- done_a / done_b  output  1  one-cycle completion pulse
- rdata  output  8  read data, valid with done pulse of a read
- err  output  1  valid with done pulse: slave error or timeout
- m_transfer  output  1  to master transfer
- m_read_write  output  1  to master READ_WRITE
- m_write_paddr / m_read_paddr  output  9  to master address inputs; both carry the latched address
- m_write_data  output  8  to master apb_write_data
- m_penable, m_pready, m_pslverr  input  1  observed master PENABLE, bus PREADY, master PSLVERR
- m_read_data  input  8  master apb_read_data_out

## Operation
- Every output is registered. Reset values: all 0, except the priority pointer, which points to A.
- States: IDLE, LOAD, XFER, RESP. One-hot encoding.
- IDLE: when any req is high, choose the winner. If only one req is high, that requester wins. If both are high, the pointer side wins. Latch the winner's rw/addr/wdata into a command register, assert its gnt, and go to LOAD.
- LOAD: drive m_read_write, both m_*_paddr and m_write_data from the command register. Set m_transfer=1. Clear the timeout counter. Go to XFER.
- XFER: hold m_transfer=1 and the command stable. Increment the counter each cycle. Exit conditions, checked in priority order:
  - m_pslverr=1 in any cycle: m_transfer=0, err=1, go to RESP.
  - m_penable & m_pready: m_transfer=0, capture m_read_data into rdata if rw=1, err=0, go to RESP.
  - counter == TIMEOUT-1: m_transfer=0, err=1, go to RESP.
- RESP: pulse the owner's done for one cycle. Drop gnt. Point the pointer at the non-owner. Go to IDLE.
- Requests sampled in RESP are ignored; arbitration happens only in IDLE.
- Command inputs are sampled only in IDLE on grant. Later changes are ignored until done.
- If a requester drops req before done, the transfer still completes and done still pulses.
- rdata holds its last value until the next read completes. err is 0 whenever done is low.

## Timing
- Grant latency: req high in IDLE at cycle N gives gnt at N+1 and m_transfer at N+2.
- Master SETUP is at N+3 and ENABLE is at N+4. With PREADY already high, done pulses at N+6.
- m_transfer deasserts in the cycle after PREADY is observed. The master therefore sees transfer=0 in its SETUP re-entry and returns to IDLE with no second transfer issued.
- Back-to-back: with both req high continuously, grants alternate A, B, A… The gap from one done to the next gnt is 1 cycle (IDLE).
- Timeout: with PREADY stuck low, err and done pulse TIMEOUT+1 cycles after m_transfer rises.
- Reset mid-transfer: all outputs return to 0 immediately (asynchronous) and the pointer returns to A. No done pulse is issued for the aborted command.
- Simultaneous PSLVERR and PREADY in the same cycle: the error wins and err=1.

## Test plan
- Single write from A: addr=0x012, wdata=0xA5, PREADY always high -> gnt_a at N+1; m_write_paddr=0x012 and m_write_data=0xA5 at N+2; done_a at N+6 with err=0; gnt_b stays 0.
- Single read from B: addr=0x105, slave returns 0x3C after 2 wait states -> m_read_write=1; done_b is 2 cycles later than the no-wait case; rdata=0x3C; err=0.
- Contention: req_a and req_b both held high from reset for 4 transfers -> grant order A, B, A, B; each done paired with the correct requester; never both gnt high.
- Timeout: TIMEOUT=8, PREADY held low -> done_a with err=1 exactly 9 cycles after m_transfer rises; m_transfer=0 afterwards; B is served next.
- Slave error: force m_pslverr during XFER -> err=1 on done; rdata unchanged from its previous value.
- Asynchronous reset asserted while in XFER -> all outputs 0 within the same cycle. After release, a pending req_b with req_a idle is granted normally.
